// File: rtl/pint_tx_arb.sv
// pint_tx_arb: shares the PINT transmit path among NREQ byte-stream requesters.
// One requester owns the path per frame. Its bytes are forwarded into the PINT TX FIFO.
// A single tx_req follows once the interface is idle and not receiving.
// The next grant waits until that transmission has completed.
// Build option: define PINT_ARB_FIXED_PRIO_EN to select lowest-index fixed priority.
// Without it (default), arbitration is round-robin.
module pint_tx_arb #(
  parameter int NREQ      = 2,
  parameter int MAX_BYTES = 15,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ-1:0]   req_cmd_type,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        tx_char,
  output logic              tx_char_latch,
  output logic              tx_req,
  output logic              tx_cmd_type,
  input  logic              pint_busy,
  input  logic              pint_rdrdy,
  output logic              err_overlen,
  input  logic              err_clr
);

  localparam int               IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STREAM    = 3'd1,
    DRAIN     = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] owner_reg, owner_sel, rr_reg;
  logic [NREQ-1:0]  grant_reg, done_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             cmd_reg;
  logic [7:0]       tx_char_reg;
  logic             tx_char_latch_reg;
  logic             err_reg;
  logic             rd_s1, rd_s2;
  logic             own_ready, accept, fire, set_err, finish, start_frame;
  logic             found;
  logic [7:0]       data_arr [NREQ];

  // Per-requester byte lanes and ready: only the current owner is ever ready
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign data_arr[gi]  = req_data[8*gi +: 8];
    assign req_ready[gi] = own_ready && (owner_reg == IDX_W'(gi));
  end

`ifdef PINT_ARB_FIXED_PRIO_EN
  // Owner selection: lowest-index valid requester wins
  always_comb begin
    owner_sel = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[k]) begin
        owner_sel = IDX_W'(k);
        found     = 1'b1;
      end
    end
  end
`else
  // Owner selection: first valid requester at or after the round-robin pointer
  always_comb begin
    owner_sel = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_reg) + k) % NREQ]) begin
        owner_sel = IDX_W'((int'(rr_reg) + k) % NREQ);
        found     = 1'b1;
      end
    end
  end
`endif

  // Two-stage synchronizer for the asynchronous rdrdy pad, matching the PINT block's own
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_s1 <= 1'b0;
      rd_s2 <= 1'b0;
    end else begin
      rd_s1 <= pint_rdrdy;
      rd_s2 <= rd_s1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next  = state_reg;
    own_ready   = 1'b0;
    fire        = 1'b0;
    set_err     = 1'b0;
    finish      = 1'b0;
    start_frame = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          start_frame = 1'b1;
          state_next  = STREAM;
        end
      end
      STREAM: begin
        if (cnt_reg == CNT_MAX) begin
          set_err    = 1'b1;
          state_next = DRAIN;
        end else begin
          own_ready = 1'b1;
          if (req_valid[owner_reg] && req_last[owner_reg]) state_next = START;
        end
      end
      DRAIN: begin
        own_ready = 1'b1;
        if (req_valid[owner_reg] && req_last[owner_reg]) state_next = START;
      end
      START: begin
        // Wait for the final byte push to land so tx_req never shares a cycle with it
        if (!tx_char_latch_reg && !pint_busy && !rd_s2) begin
          fire       = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (pint_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!pint_busy) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = own_ready && req_valid[owner_reg];

  // Frame datapath: owner/grant capture, byte forwarding, completion and error flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_reg         <= '0;
      rr_reg            <= '0;
      grant_reg         <= '0;
      done_reg          <= '0;
      cnt_reg           <= '0;
      cmd_reg           <= 1'b0;
      tx_char_reg       <= '0;
      tx_char_latch_reg <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      tx_char_latch_reg <= 1'b0;
      done_reg          <= '0;
      if (start_frame) begin
        owner_reg <= owner_sel;
        grant_reg <= NREQ'(1) << owner_sel;
        cnt_reg   <= '0;
      end
      if (accept && state_reg == STREAM) begin
        tx_char_reg       <= data_arr[owner_reg];
        tx_char_latch_reg <= 1'b1;
        cnt_reg           <= cnt_reg + 1'b1;
        if (cnt_reg == '0) cmd_reg <= req_cmd_type[owner_reg];
      end
      if (finish) begin
        done_reg  <= grant_reg;
        grant_reg <= '0;
        rr_reg    <= (int'(owner_reg) == NREQ - 1) ? '0 : owner_reg + 1'b1;
      end
      if (set_err)      err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;
    end
  end

  assign grant         = grant_reg;
  assign done          = done_reg;
  assign tx_char       = tx_char_reg;
  assign tx_char_latch = tx_char_latch_reg;
  assign tx_req        = fire;
  assign tx_cmd_type   = fire & cmd_reg;
  assign err_overlen   = err_reg;

endmodule

// File: tb/tb_pint_tx_arb.sv
// tb_pint_tx_arb: randomized and directed frames for pint_tx_arb, checked against a
// frame-level reference model (arbitration rule, byte truncation, sticky error).
module tb_pint_tx_arb;

  localparam int MAXB = 15;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = '0, req_last = '0, req_cmd_type = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready, grant, done;
  logic [7:0]  tx_char;
  logic        tx_char_latch, tx_req, tx_cmd_type;
  logic        pint_busy = 1'b0, pint_rdrdy = 1'b0, err_clr = 1'b0;
  logic        err_overlen;

  pint_tx_arb #(.NREQ(2), .MAX_BYTES(MAXB), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_cmd_type(req_cmd_type), .req_ready(req_ready),
    .grant(grant), .done(done),
    .tx_char(tx_char), .tx_char_latch(tx_char_latch),
    .tx_req(tx_req), .tx_cmd_type(tx_cmd_type),
    .pint_busy(pint_busy), .pint_rdrdy(pint_rdrdy),
    .err_overlen(err_overlen), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Pending stimulus per requester: {cmd, last, data}
  logic [9:0] bq0[$], bq1[$];
  logic [7:0] got_q[$], exp_q[$];
  int         exp_owner, exp_len, mdl_rr = 0;
  logic       exp_cmd, got_cmd, mdl_err = 1'b0;
  bit         in_frame = 0, gap_en = 0, rd_en = 0;
  int         txreq_n = 0, txreq_total = 0, frames_done = 0, frames_sent = 0;
  logic [1:0] prev_valid = '0, rd_hist = '0;
  logic [9:0] mon_e;
  int         mon_sz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int i);
    return 2'b01 << i;
  endfunction

  // Arbitration rule: fixed priority, or first valid at/after the rr pointer
  function automatic int pick(input logic [1:0] v, input int rr);
`ifdef PINT_ARB_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    for (int k = 0; k < 2; k++) if (v[(rr + k) % 2]) return (rr + k) % 2;
    return 0;
`endif
  endfunction

  task automatic add_frame(input int i, input int len, input logic cmd);
    logic [9:0] e;
    for (int k = 0; k < len; k++) begin
      // only the first byte's cmd bit is meaningful; the rest are noise
      e = {(k == 0) ? cmd : 1'($urandom), (k == len - 1), 8'($urandom)};
      if (i == 0) bq0.push_back(e);
      else        bq1.push_back(e);
    end
    frames_sent++;
  endtask

  task automatic apply();
    req_valid = '0;
    req_last  = '0;
    req_cmd_type = '0;
    if (bq0.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      req_valid[0] = 1'b1; req_data[7:0] = bq0[0][7:0];
      req_last[0] = bq0[0][8]; req_cmd_type[0] = bq0[0][9];
    end
    if (bq1.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      req_valid[1] = 1'b1; req_data[15:8] = bq1[0][7:0];
      req_last[1] = bq1[0][8]; req_cmd_type[1] = bq1[0][9];
    end
    if (rd_en) pint_rdrdy = ($urandom_range(0, 5) == 0);
  endtask

  // One handshake step: ready is sampled mid-cycle, accepted bytes retired after the edge
  task automatic step();
    logic [1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    if (acc[0]) void'(bq0.pop_front());
    if (acc[1]) void'(bq1.pop_front());
    apply();
  endtask

  task automatic drive(input int budget);
    int n;
    n = 0;
    apply();
    while ((bq0.size() + bq1.size()) > 0 && n < budget) begin
      step();
      n++;
    end
    check("drive_done", bq0.size() + bq1.size(), 0);
    req_valid = '0;
    if (rd_en) pint_rdrdy = 1'b0;
  endtask

  task automatic wait_frames();
    int n;
    n = 0;
    while (frames_done < frames_sent && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("frames_done", frames_done, frames_sent);
    #1;
  endtask

  // PINT responder: busy rises the cycle after tx_req and stays up a few cycles
  always @(negedge clk) begin
    if (resetn && tx_req) begin
      @(posedge clk); #1 pint_busy = 1'b1;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 pint_busy = 1'b0;
    end
  end

  always @(posedge clk) rd_hist <= {rd_hist[0], pint_rdrdy};

  // Monitor: collects pushed bytes and tx_req per frame, scores each frame at done
  always @(negedge clk) begin
    if (!resetn) begin
      got_q.delete();
      txreq_n  = 0;
      in_frame = 0;
      mdl_rr   = 0;
      mdl_err  = 1'b0;
    end else begin
      if (tx_req) begin
        check("txreq_legal", {29'd0, tx_char_latch, pint_busy, rd_hist[1]}, 0);
        txreq_n++;
        txreq_total++;
        got_cmd = tx_cmd_type;
      end
      if (tx_char_latch) got_q.push_back(tx_char);
      if (grant != 2'b00 && !in_frame) begin
        exp_owner = pick(prev_valid, mdl_rr);
        check("grant", grant, onehot(exp_owner));
        in_frame = 1;
        exp_q.delete();
        exp_len = 0;
        exp_cmd = 1'b0;
        mon_sz  = (exp_owner == 0) ? bq0.size() : bq1.size();
        for (int k = 0; k < mon_sz; k++) begin
          mon_e = (exp_owner == 0) ? bq0[k] : bq1[k];
          if (k == 0) exp_cmd = mon_e[9];
          if (exp_len < MAXB) exp_q.push_back(mon_e[7:0]);
          exp_len++;
          if (mon_e[8]) break;
        end
      end
      if (done != 2'b00) begin
        check("done", done, onehot(exp_owner));
        check("grant_clr", grant, 0);
        check("nbytes", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
          if (k < got_q.size()) check("byte", got_q[k], exp_q[k]);
        check("txreq_cnt", txreq_n, 1);
        check("cmd", got_cmd, exp_cmd);
        if (exp_len > MAXB) mdl_err = 1'b1;
        check("err", err_overlen, mdl_err);
        $display("[TB] frame req%0d len=%0d latched=%0d cmd=%0d err=%0d",
                 exp_owner, exp_len, got_q.size(), got_cmd, err_overlen);
        mdl_rr   = (exp_owner + 1) % 2;
        in_frame = 0;
        frames_done++;
        got_q.delete();
        txreq_n = 0;
      end
    end
    prev_valid = req_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n;
    // T1: reset with both requesters asserting
    resetn = 1'b0; req_valid = 2'b11; req_data = 16'hFFFF; req_last = 2'b11; req_cmd_type = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_ready", req_ready, 0);
    check("rst_tx", {tx_char, tx_char_latch, tx_req, tx_cmd_type}, 0);
    check("rst_done", done, 0);
    check("rst_err", err_overlen, 0);
    @(posedge clk); #1;
    req_valid = '0; req_last = '0; req_cmd_type = '0;
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // T2: single two-byte frame from requester 0, cmd 1
    bq0.push_back({1'b1, 1'b0, 8'hA5});
    bq0.push_back({1'b1, 1'b1, 8'h3C});
    frames_sent++;
    drive(200);
    wait_frames();

    // T3: both requesters continuously valid with 1-byte frames
    for (int k = 0; k < 4; k++) begin
      add_frame(0, 1, 1'($urandom));
      add_frame(1, 1, 1'($urandom));
    end
    drive(500);
    wait_frames();

    // T4: rx in progress around START holds tx_req off
    pint_rdrdy = 1'b1;
    add_frame(0, 1, 1'b1);
    drive(100);
    base = txreq_total;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t4_held", txreq_total - base, 0);
    @(posedge clk); #1 pint_rdrdy = 1'b0;
    wait_frames();

    // T5: 20-byte frame, 15 bytes forwarded, sticky error then clear
    add_frame(0, 20, 1'b1);
    drive(300);
    wait_frames();
    check("t5_err", err_overlen, 1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0; mdl_err = 1'b0;
    @(negedge clk);
    check("t5_err_clr", err_overlen, 0);
    @(posedge clk); #1;

    // T6: reset after 3 bytes of a 10-byte frame
    base = txreq_total;
    add_frame(0, 10, 1'b0);
    apply();
    n = 0;
    while (got_q.size() < 3 && n < 100) begin
      step();
      n++;
    end
    check("t6_bytes", got_q.size(), 3);
    resetn = 1'b0; req_valid = '0;
    bq0.delete();
    frames_sent--;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_grant", grant, 0);
    check("t6_ready", req_ready, 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_no_txreq", txreq_total - base, 0);
    @(posedge clk); #1;
    add_frame(0, 3, 1'b1);
    drive(200);
    wait_frames();

    // Random traffic: gaps, random rdrdy, mixed lengths including overlength
    gap_en = 1; rd_en = 1;
    for (int k = 0; k < 14; k++)
      add_frame($urandom_range(0, 1), $urandom_range(1, 18), 1'($urandom));
    drive(5000);
    wait_frames();
    gap_en = 0; rd_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
